// File: rtl/bus_fabric_pkg.sv
`default_nettype none
// ============================================================================
// bus_fabric_pkg : shared types and helpers for the bus_fabric interconnect
// Revision: 1.0
// ============================================================================
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } fab_state_t;

   // Wide enough to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DECODE  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// bus_addr_decoder : upper address bits -> one-hot slave select + decode error
// Revision: 1.0
// ============================================================================
module bus_addr_decoder #(
   parameter int ADDR_W     = 16,
   parameter int SEL_W      = 4,
   parameter int NUM_SLAVES = 5
) (
   input  logic [ADDR_W-1:0]     addr_i,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic                  decode_err_o
);

   logic [SEL_W-1:0]        w_idx;
   logic [ADDR_W-SEL_W-1:0] w_unused_low;

   assign w_idx        = addr_i[ADDR_W-1 -: SEL_W];
   assign w_unused_low = addr_i[ADDR_W-SEL_W-1:0];

   // Unsigned compare so an index field wider than the slave count still decodes.
   always_comb begin
      sel_o        = '0;
      decode_err_o = (32'(w_idx) >= 32'(NUM_SLAVES));
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (32'(w_idx) == 32'(i)) begin
            sel_o[i] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// bus_fabric : single-master shared-bus interconnect with registered decode,
//              req/ack handshake and timeout error response
// Revision: 1.0
// ============================================================================
module bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 16,
   parameter int NUM_SLAVES = 5,
   parameter int SEL_W      = 4,
   parameter int OP_W       = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         m_req_i,
   input  logic                         m_we_i,
   input  logic [ADDR_W-1:0]            m_addr_i,
   input  logic [DATA_W-1:0]            m_wdata_i,
   input  logic [OP_W-1:0]              m_opcode_i,
   output logic                         m_done_o,
   output logic                         m_err_o,
   output logic [DATA_W-1:0]            m_rdata_o,
   output logic                         m_busy_o,
   output logic [NUM_SLAVES-1:0]        s_sel_o,
   output logic                         s_we_o,
   output logic [ADDR_W-1:0]            s_addr_o,
   output logic [DATA_W-1:0]            s_wdata_o,
   output logic [OP_W-1:0]              s_opcode_o,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
   input  logic [NUM_SLAVES-1:0]        s_ack_i
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   fab_state_t              state_q,  state_d;
   logic                    we_q,     we_d;
   logic [ADDR_W-1:0]       addr_q,   addr_d;
   logic [DATA_W-1:0]       wdata_q,  wdata_d;
   logic [OP_W-1:0]         opcode_q, opcode_d;
   logic [NUM_SLAVES-1:0]   sel_q,    sel_d;
   logic                    err_q,    err_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;
   logic [DATA_W-1:0]       rdata_q,  rdata_d;

   logic                    w_accept;
   logic [ADDR_W-1:0]       w_cap_addr;
   logic [NUM_SLAVES-1:0]   w_dec_sel;
   logic                    w_dec_err;
   logic                    w_ack_hit;
   logic                    w_timeout;
   logic [DATA_W-1:0]       w_rdata_mux;

   // Decode the address as it is being captured so the select is registered.
   assign w_accept   = (state_q == IDLE) && m_req_i;
   assign w_cap_addr = w_accept ? m_addr_i : addr_q;

   bus_addr_decoder #(
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W),
      .NUM_SLAVES (NUM_SLAVES)
   ) u_dec (
      .addr_i       (w_cap_addr),
      .sel_o        (w_dec_sel),
      .decode_err_o (w_dec_err)
   );

   assign w_ack_hit = |(s_ack_i & sel_q);
   assign w_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      w_rdata_mux = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            w_rdata_mux = s_rdata_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = w_cap_addr;
      wdata_d  = wdata_q;
      opcode_d = opcode_q;
      sel_d    = sel_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (m_req_i) begin
               we_d     = m_we_i;
               wdata_d  = m_wdata_i;
               opcode_d = m_opcode_i;
               cnt_d    = '0;
               if (w_dec_err) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  sel_d   = '0;
               end else begin
                  state_d = ACCESS;
                  err_d   = 1'b0;
                  sel_d   = w_dec_sel;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            // An ack arriving in the timeout cycle still completes cleanly.
            if (w_ack_hit) begin
               if (!we_q) rdata_d = w_rdata_mux;
               err_d   = 1'b0;
               sel_d   = '0;
               state_d = RESP;
            end else if (w_timeout) begin
               if (!we_q) rdata_d = '0;
               err_d   = 1'b1;
               sel_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         opcode_q <= '0;
         sel_q    <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         opcode_q <= opcode_d;
         sel_q    <= sel_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
      end
   end

   assign m_done_o   = (state_q == RESP);
   assign m_err_o    = (state_q == RESP) && err_q;
   assign m_busy_o   = (state_q != IDLE);
   assign m_rdata_o  = rdata_q;
   assign s_sel_o    = sel_q;
   assign s_we_o     = we_q && (state_q == ACCESS);
   assign s_addr_o   = addr_q;
   assign s_wdata_o  = wdata_q;
   assign s_opcode_o = opcode_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
// tb_bus_fabric : directed self-checking bench for bus_fabric
// Revision: 1.0
// ============================================================================
module tb_bus_fabric;
   import bus_fabric_pkg::*;

   localparam int DW = 256;
   localparam int AW = 16;
   localparam int NS = 5;
   localparam int SW = 4;
   localparam int OW = 8;
   localparam int TO = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             m_req;
   logic             m_we;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_wdata;
   logic [OW-1:0]    m_opcode;
   logic             m_done;
   logic             m_err;
   logic [DW-1:0]    m_rdata;
   logic             m_busy;
   logic [NS-1:0]    s_sel;
   logic             s_we;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic [OW-1:0]    s_opcode;
   logic [NS*DW-1:0] s_rdata;
   logic [NS-1:0]    s_ack;
   logic [NS-1:0]    auto_ack;
   logic [NS-1:0]    force_ack;
   logic [DW-1:0]    slice_val [NS];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Slaves answering in the same cycle they are selected, plus a raw override.
   assign s_ack = (s_sel & auto_ack) | force_ack;

   bus_fabric #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_SLAVES(NS), .SEL_W(SW), .OP_W(OW), .TIMEOUT(TO)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .m_req_i    (m_req),
      .m_we_i     (m_we),
      .m_addr_i   (m_addr),
      .m_wdata_i  (m_wdata),
      .m_opcode_i (m_opcode),
      .m_done_o   (m_done),
      .m_err_o    (m_err),
      .m_rdata_o  (m_rdata),
      .m_busy_o   (m_busy),
      .s_sel_o    (s_sel),
      .s_we_o     (s_we),
      .s_addr_o   (s_addr),
      .s_wdata_o  (s_wdata),
      .s_opcode_o (s_opcode),
      .s_rdata_i  (s_rdata),
      .s_ack_i    (s_ack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_vec++;
      if ({m_busy, m_done, m_err, s_sel, s_we} !== '0) begin
         n_err++;
         $display("FAIL reset_ctrl: busy=%b done=%b err=%b sel=%b we=%b want all 0",
                  m_busy, m_done, m_err, s_sel, s_we);
      end
      n_vec++;
      if (m_rdata !== '0 || s_addr !== '0 || s_wdata !== '0 || s_opcode !== '0) begin
         n_err++;
         $display("FAIL reset_data: rdata=%h addr=%h want 0", m_rdata, s_addr);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_read_slave1();
      auto_ack = 5'b00010;
      m_req = 1'b1; m_we = 1'b0; m_addr = 16'h1004; m_opcode = 8'h11;
      n_vec++;
      if (m_busy !== 1'b0) begin
         n_err++; $display("FAIL rd_idle_busy: got %b want 0", m_busy);
      end
      step();
      m_req = 1'b0;
      n_vec++;
      if (s_sel !== 5'b00010 || m_done !== 1'b0 || m_busy !== 1'b1) begin
         n_err++;
         $display("FAIL rd_access: sel=%b done=%b busy=%b want 00010/0/1", s_sel, m_done, m_busy);
      end
      step();
      n_vec++;
      if (m_done !== 1'b1 || m_err !== 1'b0 || s_sel !== 5'b00000) begin
         n_err++;
         $display("FAIL rd_resp: done=%b err=%b sel=%b want 1/0/00000", m_done, m_err, s_sel);
      end
      n_vec++;
      if (m_rdata !== {32{8'hA5}}) begin
         n_err++; $display("FAIL rd_data: got %h want %h", m_rdata, {32{8'hA5}});
      end
      step();
      n_vec++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_rdata !== {32{8'hA5}}) begin
         n_err++;
         $display("FAIL rd_after: done=%b busy=%b rdata=%h want 0/0/A5..", m_done, m_busy, m_rdata);
      end
      auto_ack = '0;
   endtask

   task automatic test_write_slave3();
      m_req = 1'b1; m_we = 1'b1; m_addr = 16'h3000; m_wdata = 256'h1234; m_opcode = 8'h5A;
      step();
      m_req = 1'b0; m_addr = 16'hFFFF; m_wdata = '1; m_opcode = 8'hFF;
      for (int c = 1; c <= 4; c++) begin
         n_vec++;
         if (s_sel !== 5'b01000 || s_we !== 1'b1 || s_addr !== 16'h3000 ||
             s_wdata !== 256'h1234 || s_opcode !== 8'h5A || m_done !== 1'b0) begin
            n_err++;
            $display("FAIL wr_hold c%0d: sel=%b we=%b addr=%h wdata=%h op=%h done=%b want 01000/1/3000/1234/5a/0",
                     c, s_sel, s_we, s_addr, s_wdata, s_opcode, m_done);
         end
         if (c == 4) force_ack = 5'b01000;
         step();
      end
      force_ack = '0;
      n_vec++;
      if (m_done !== 1'b1 || m_err !== 1'b0 || s_we !== 1'b0 || s_sel !== 5'b00000) begin
         n_err++;
         $display("FAIL wr_resp: done=%b err=%b we=%b sel=%b want 1/0/0/00000", m_done, m_err, s_we, s_sel);
      end
      n_vec++;
      if (m_rdata !== {32{8'hA5}}) begin
         n_err++; $display("FAIL wr_rdata_kept: got %h want %h", m_rdata, {32{8'hA5}});
      end
      step();
   endtask

   task automatic test_decode_err();
      m_req = 1'b1; m_we = 1'b0; m_addr = 16'h7000;
      step();
      m_req = 1'b0;
      n_vec++;
      if (m_done !== 1'b1 || m_err !== 1'b1 || s_sel !== 5'b00000) begin
         n_err++;
         $display("FAIL decode_err: done=%b err=%b sel=%b want 1/1/00000 (code %0d)",
                  m_done, m_err, s_sel, ERR_DECODE);
      end
      step();
      n_vec++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || s_sel !== 5'b00000) begin
         n_err++;
         $display("FAIL decode_after: done=%b busy=%b sel=%b want 0/0/00000", m_done, m_busy, s_sel);
      end
   endtask

   task automatic test_reset_mid();
      m_req = 1'b1; m_we = 1'b0; m_addr = 16'h4000;
      step();
      m_req = 1'b0;
      n_vec++;
      if (s_sel !== 5'b10000) begin
         n_err++; $display("FAIL rst_mid_sel: got %b want 10000", s_sel);
      end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_vec++;
      if (s_sel !== 5'b00000 || m_busy !== 1'b0 || m_rdata !== '0 || m_done !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: sel=%b busy=%b done=%b rdata=%h want 0", s_sel, m_busy, m_done, m_rdata);
      end
      step();
      n_vec++;
      if (m_done !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_nodone: got %b want 0", m_done);
      end
      auto_ack = 5'b10000;
      m_req = 1'b1; m_addr = 16'h4008;
      step();
      m_req = 1'b0;
      step();
      n_vec++;
      if (m_done !== 1'b1 || m_err !== 1'b0 || m_rdata !== slice_val[4]) begin
         n_err++;
         $display("FAIL rst_recover: done=%b err=%b rdata=%h want 1/0/%h", m_done, m_err, m_rdata, slice_val[4]);
      end
      step();
      auto_ack = '0;
   endtask

   task automatic test_timeout();
      m_req = 1'b1; m_we = 1'b0; m_addr = 16'h2000;
      step();
      m_req = 1'b0;
      force_ack = 5'b00001;
      for (int c = 1; c <= TO; c++) begin
         n_vec++;
         if (m_done !== 1'b0 || s_sel !== 5'b00100) begin
            n_err++;
            $display("FAIL to_wait c%0d: done=%b sel=%b want 0/00100", c, m_done, s_sel);
         end
         step();
      end
      force_ack = '0;
      n_vec++;
      if (m_done !== 1'b1 || m_err !== 1'b1 || m_rdata !== '0) begin
         n_err++;
         $display("FAIL timeout: done=%b err=%b rdata=%h want 1/1/0 (code %0d)",
                  m_done, m_err, m_rdata, ERR_TIMEOUT);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3];
      int            slot  [3];
      addrs[0] = 16'h0010; addrs[1] = 16'h1020; addrs[2] = 16'h4030;
      slot[0]  = 0;        slot[1]  = 1;        slot[2]  = 4;
      auto_ack = '1;
      m_req = 1'b1; m_we = 1'b0; m_addr = addrs[0];
      for (int t = 0; t < 3; t++) begin
         n_vec++;
         if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle t%0d: busy=%b done=%b want 0/0", t, m_busy, m_done);
         end
         step();
         n_vec++;
         if (s_sel !== NS'(1 << slot[t]) || m_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_access t%0d: sel=%b done=%b want %b/0", t, s_sel, m_done, NS'(1 << slot[t]));
         end
         if (t < 2) m_addr = addrs[t+1];
         else       m_req  = 1'b0;
         step();
         n_vec++;
         if (m_done !== 1'b1 || m_err !== 1'b0 || m_rdata !== slice_val[slot[t]]) begin
            n_err++;
            $display("FAIL b2b_resp t%0d: done=%b err=%b rdata=%h want 1/0/%h",
                     t, m_done, m_err, m_rdata, slice_val[slot[t]]);
         end
         step();
      end
      n_vec++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
         n_err++; $display("FAIL b2b_end: done=%b busy=%b want 0/0", m_done, m_busy);
      end
      auto_ack = '0;
   endtask

   initial begin
      slice_val[0] = {32{8'h10}};
      slice_val[1] = {32{8'hA5}};
      slice_val[2] = {32{8'h22}};
      slice_val[3] = {32{8'h33}};
      slice_val[4] = {32{8'h44}};
      for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = slice_val[i];
      reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_opcode = '0;
      auto_ack = '0; force_ack = '0;

      test_reset();
      test_read_slave1();
      test_write_slave3();
      test_decode_err();
      test_reset_mid();
      test_timeout();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
